// File: rtl/store_buffer_mp.sv
// Store buffer: multi-lane allocate/commit, in-order drain to the D$, per-byte load forwarding.
// Senior (committed) stores survive a flush; speculative ones are discarded.
module store_buffer_mp #(
  parameter  int SB_DEPTH = 16,
  parameter  int ALLOC_W  = 2,
  parameter  int COMMIT_W = 2,
  parameter  int PLEN     = 32,
  parameter  int XLEN     = 32,
  localparam int IDW      = $clog2(SB_DEPTH),
  localparam int BW       = XLEN / 8,
  localparam int OFS      = $clog2(BW)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [ALLOC_W-1:0]        alloc_req_i,
  output logic                      alloc_gnt_o,
  output logic [ALLOC_W*IDW-1:0]    alloc_id_o,
  input  logic                      ex_valid_i,
  input  logic [IDW-1:0]            ex_sb_id_i,
  input  logic [PLEN-1:0]           ex_addr_i,
  input  logic [XLEN-1:0]           ex_data_i,
  input  logic [BW-1:0]             ex_be_i,
  input  logic [COMMIT_W-1:0]       commit_valid_i,
  input  logic [COMMIT_W*IDW-1:0]   commit_sb_id_i,
  output logic                      dcache_req_valid_o,
  input  logic                      dcache_req_ready_i,
  output logic [PLEN-1:0]           dcache_req_addr_o,
  output logic [XLEN-1:0]           dcache_req_data_o,
  output logic [BW-1:0]             dcache_req_be_o,
  input  logic [PLEN-1:0]           load_addr_i,
  input  logic [BW-1:0]             load_be_i,
  output logic                      load_hit_o,
  output logic                      load_stall_o,
  output logic [XLEN-1:0]           load_data_o,
  output logic [IDW:0]              count_o,
  input  logic                      flush_i
);

  localparam int WAW = PLEN - OFS;
  localparam logic [IDW:0] MAX_FILL = (IDW+1)'(SB_DEPTH - ALLOC_W);

  logic [SB_DEPTH-1:0] valid_reg, committed_reg, addr_valid_reg;
  logic [WAW-1:0]      word_addr_reg [SB_DEPTH];
  logic [XLEN-1:0]     data_reg      [SB_DEPTH];
  logic [BW-1:0]       be_reg        [SB_DEPTH];
  logic [IDW-1:0]      head_reg, tail_reg, head_next, tail_next;
  logic [IDW:0]        count_reg, count_next;

  logic [IDW:0]        n_alloc, committed_cnt;
  logic [IDW-1:0]      alloc_id [ALLOC_W];
  logic                alloc_fire, ex_write, drain;
  logic [SB_DEPTH-1:0] commit_hit;
  logic [BW-1:0]       fwd_found;
  logic [XLEN-1:0]     fwd_data;
  logic [IDW-1:0]      scan_idx;
  logic                unused_low_bits;

  assign unused_low_bits = ^{ex_addr_i[OFS-1:0], load_addr_i[OFS-1:0]};

  // All-or-nothing grant based on registered occupancy only.
  assign alloc_gnt_o = (count_reg <= MAX_FILL);
  assign alloc_fire  = alloc_gnt_o & ~flush_i & (|alloc_req_i);
  assign ex_write    = ex_valid_i & ~flush_i & valid_reg[ex_sb_id_i];

  always_comb begin
    n_alloc = '0;
    for (int k = 0; k < ALLOC_W; k++) begin
      alloc_id[k] = tail_reg + n_alloc[IDW-1:0];
      n_alloc     = n_alloc + (IDW+1)'(alloc_req_i[k]);
    end
  end

  for (genvar gi = 0; gi < ALLOC_W; gi++) begin : g_alloc_id
    assign alloc_id_o[gi*IDW +: IDW] = alloc_id[gi];
  end

  always_comb begin
    commit_hit = '0;
    for (int c = 0; c < COMMIT_W; c++) begin
      if (commit_valid_i[c]) commit_hit[commit_sb_id_i[c*IDW +: IDW]] = 1'b1;
    end
  end

  assign dcache_req_valid_o = valid_reg[head_reg] & committed_reg[head_reg] & addr_valid_reg[head_reg];
  assign dcache_req_addr_o  = {word_addr_reg[head_reg], {OFS{1'b0}}};
  assign dcache_req_data_o  = data_reg[head_reg];
  assign dcache_req_be_o    = be_reg[head_reg];
  assign drain              = dcache_req_valid_o & dcache_req_ready_i;

  // Senior entries remaining after this cycle's commits and drain.
  always_comb begin
    committed_cnt = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      committed_cnt = committed_cnt + (IDW+1)'(valid_reg[i] & (committed_reg[i] | commit_hit[i]));
    end
    committed_cnt = committed_cnt - (IDW+1)'(drain);
  end

  assign head_next = head_reg + IDW'(drain);

  always_comb begin
    tail_next  = tail_reg;
    count_next = count_reg - (IDW+1)'(drain);
    if (flush_i) begin
      tail_next  = head_next + committed_cnt[IDW-1:0];
      count_next = committed_cnt;
    end else if (alloc_fire) begin
      tail_next  = tail_reg + n_alloc[IDW-1:0];
      count_next = count_reg + n_alloc - (IDW+1)'(drain);
    end
  end

  // Scan oldest to youngest so that younger matches overwrite older bytes.
  always_comb begin
    fwd_found = '0;
    fwd_data  = '0;
    scan_idx  = '0;
    for (int j = 0; j < SB_DEPTH; j++) begin
      scan_idx = head_reg + IDW'(j);
      if (valid_reg[scan_idx] && addr_valid_reg[scan_idx] &&
          word_addr_reg[scan_idx] == load_addr_i[PLEN-1:OFS]) begin
        for (int b = 0; b < BW; b++) begin
          if (be_reg[scan_idx][b] && load_be_i[b]) begin
            fwd_found[b]       = 1'b1;
            fwd_data[b*8 +: 8] = data_reg[scan_idx][b*8 +: 8];
          end
        end
      end
    end
  end

  assign load_hit_o   = (|load_be_i) && (fwd_found == load_be_i);
  assign load_stall_o = (|fwd_found) && (fwd_found != load_be_i);
  assign load_data_o  = fwd_data;
  assign count_o      = count_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_reg      <= '0;
      committed_reg  <= '0;
      addr_valid_reg <= '0;
      head_reg       <= '0;
      tail_reg       <= '0;
      count_reg      <= '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
        word_addr_reg[i] <= '0;
        data_reg[i]      <= '0;
        be_reg[i]        <= '0;
      end
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
      for (int i = 0; i < SB_DEPTH; i++) begin
        if (commit_hit[i] && valid_reg[i]) committed_reg[i] <= 1'b1;
        if (ex_write && ex_sb_id_i == IDW'(i)) begin
          word_addr_reg[i]  <= ex_addr_i[PLEN-1:OFS];
          data_reg[i]       <= ex_data_i;
          be_reg[i]         <= ex_be_i;
          addr_valid_reg[i] <= 1'b1;
        end
        if (drain && head_reg == IDW'(i)) begin
          valid_reg[i]      <= 1'b0;
          committed_reg[i]  <= 1'b0;
          addr_valid_reg[i] <= 1'b0;
        end
        if (flush_i && !(committed_reg[i] || commit_hit[i])) begin
          valid_reg[i]      <= 1'b0;
          addr_valid_reg[i] <= 1'b0;
        end
      end
      for (int k = 0; k < ALLOC_W; k++) begin
        if (alloc_fire && alloc_req_i[k]) begin
          valid_reg[alloc_id[k]]      <= 1'b1;
          committed_reg[alloc_id[k]]  <= 1'b0;
          addr_valid_reg[alloc_id[k]] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_store_buffer_mp.sv
// Directed bench for store_buffer_mp; D$ writes are checked against a queue of expected stores.
module tb_store_buffer_mp;
  localparam int SB_DEPTH = 16;
  localparam int ALLOC_W  = 2;
  localparam int COMMIT_W = 2;
  localparam int PLEN     = 32;
  localparam int XLEN     = 32;
  localparam int IDW      = 4;
  localparam int BW       = 4;

  logic                    clk_i = 1'b0;
  logic                    rst_ni;
  logic [ALLOC_W-1:0]      alloc_req_i;
  logic                    alloc_gnt_o;
  logic [ALLOC_W*IDW-1:0]  alloc_id_o;
  logic                    ex_valid_i;
  logic [IDW-1:0]          ex_sb_id_i;
  logic [PLEN-1:0]         ex_addr_i;
  logic [XLEN-1:0]         ex_data_i;
  logic [BW-1:0]           ex_be_i;
  logic [COMMIT_W-1:0]     commit_valid_i;
  logic [COMMIT_W*IDW-1:0] commit_sb_id_i;
  logic                    dcache_req_valid_o;
  logic                    dcache_req_ready_i;
  logic [PLEN-1:0]         dcache_req_addr_o;
  logic [XLEN-1:0]         dcache_req_data_o;
  logic [BW-1:0]           dcache_req_be_o;
  logic [PLEN-1:0]         load_addr_i;
  logic [BW-1:0]           load_be_i;
  logic                    load_hit_o;
  logic                    load_stall_o;
  logic [XLEN-1:0]         load_data_o;
  logic [IDW:0]            count_o;
  logic                    flush_i;

  store_buffer_mp #(.SB_DEPTH(SB_DEPTH), .ALLOC_W(ALLOC_W), .COMMIT_W(COMMIT_W),
                    .PLEN(PLEN), .XLEN(XLEN)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .alloc_req_i(alloc_req_i), .alloc_gnt_o(alloc_gnt_o), .alloc_id_o(alloc_id_o),
    .ex_valid_i(ex_valid_i), .ex_sb_id_i(ex_sb_id_i), .ex_addr_i(ex_addr_i),
    .ex_data_i(ex_data_i), .ex_be_i(ex_be_i),
    .commit_valid_i(commit_valid_i), .commit_sb_id_i(commit_sb_id_i),
    .dcache_req_valid_o(dcache_req_valid_o), .dcache_req_ready_i(dcache_req_ready_i),
    .dcache_req_addr_o(dcache_req_addr_o), .dcache_req_data_o(dcache_req_data_o),
    .dcache_req_be_o(dcache_req_be_o),
    .load_addr_i(load_addr_i), .load_be_i(load_be_i), .load_hit_o(load_hit_o),
    .load_stall_o(load_stall_o), .load_data_o(load_data_o),
    .count_o(count_o), .flush_i(flush_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [PLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [BW-1:0]   be;
  } st_t;

  st_t exp_q[$];
  int  vectors = 0;
  int  fails   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic ex_wr(input logic [IDW-1:0] id, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be);
    ex_valid_i = 1'b1;
    ex_sb_id_i = id;
    ex_addr_i  = a;
    ex_data_i  = d;
    ex_be_i    = be;
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    st_t s;
    s.addr = a;
    s.data = d;
    s.be   = be;
    exp_q.push_back(s);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    settle();
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_dvalid", 64'(dcache_req_valid_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
  endtask

  // D$ write monitor: a handshake seen at the falling edge completes at the next rising edge.
  always @(negedge clk_i) begin
    if (rst_ni && dcache_req_valid_o && dcache_req_ready_i) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_drain", 64'(dcache_req_addr_o), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        st_t s;
        s = exp_q.pop_front();
        chk("drain_addr", 64'(dcache_req_addr_o), 64'(s.addr));
        chk("drain_data", 64'(dcache_req_data_o), 64'(s.data));
        chk("drain_be",   64'(dcache_req_be_o),   64'(s.be));
        $display("drain addr=%08h data=%08h be=%h", dcache_req_addr_o, dcache_req_data_o, dcache_req_be_o);
      end
    end
  end

  initial begin
    rst_ni = 1'b0;
    alloc_req_i = '0; ex_valid_i = 1'b0; ex_sb_id_i = '0; ex_addr_i = '0; ex_data_i = '0;
    ex_be_i = '0; commit_valid_i = '0; commit_sb_id_i = '0; dcache_req_ready_i = 1'b0;
    load_addr_i = '0; load_be_i = 4'hF; flush_i = 1'b0;

    // Reset values
    #2;
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_gnt", 64'(alloc_gnt_o), 64'd1);
    chk("rst_dvalid", 64'(dcache_req_valid_o), 64'd0);
    chk("rst_hit", 64'(load_hit_o), 64'd0);
    chk("rst_stall", 64'(load_stall_o), 64'd0);
    chk("rst_ldata", 64'(load_data_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();

    // Fill to 16 with two lanes per cycle
    for (int c = 0; c < 8; c++) begin
      alloc_req_i = 2'b11;
      settle();
      chk("fill_gnt", 64'(alloc_gnt_o), 64'd1);
      chk("fill_id0", 64'(alloc_id_o[IDW-1:0]), 64'(2*c));
      chk("fill_id1", 64'(alloc_id_o[2*IDW-1:IDW]), 64'(2*c+1));
      tick();
    end
    alloc_req_i = '0;
    settle();
    chk("full_count", 64'(count_o), 64'd16);
    chk("full_gnt", 64'(alloc_gnt_o), 64'd0);

    ex_wr(4'd0, 32'h40, 32'h1111_1111, 4'hF);
    commit_valid_i = 2'b01; commit_sb_id_i = {4'd0, 4'd0};
    push_exp(32'h40, 32'h1111_1111, 4'hF);
    tick();
    ex_valid_i = 1'b0; commit_valid_i = '0;
    settle();
    chk("full_dvalid", 64'(dcache_req_valid_o), 64'd1);
    // Drain plus a two-lane request while full: drain happens, alloc is refused
    dcache_req_ready_i = 1'b1; alloc_req_i = 2'b11;
    settle();
    chk("full_alloc_gnt", 64'(alloc_gnt_o), 64'd0);
    tick();
    alloc_req_i = '0; dcache_req_ready_i = 1'b0;
    settle();
    chk("after_drain_count", 64'(count_o), 64'd15);
    chk("after_drain_gnt", 64'(alloc_gnt_o), 64'd0);

    ex_wr(4'd1, 32'h44, 32'h2222_2222, 4'hF);
    commit_valid_i = 2'b10; commit_sb_id_i = {4'd1, 4'd0};
    push_exp(32'h44, 32'h2222_2222, 4'hF);
    tick();
    ex_valid_i = 1'b0; commit_valid_i = '0; dcache_req_ready_i = 1'b1;
    tick();
    dcache_req_ready_i = 1'b0;
    settle();
    chk("two_free_count", 64'(count_o), 64'd14);
    chk("two_free_gnt", 64'(alloc_gnt_o), 64'd1);
    // Only lane 1 requests: it takes the wrapped tail id 0
    alloc_req_i = 2'b10;
    settle();
    chk("wrap_id_lane1", 64'(alloc_id_o[2*IDW-1:IDW]), 64'd0);
    tick();
    alloc_req_i = '0;
    settle();
    chk("wrap_count", 64'(count_o), 64'd15);
    do_reset();

    // Byte forwarding, youngest byte wins
    alloc_req_i = 2'b11;
    tick();
    alloc_req_i = '0;
    ex_wr(4'd0, 32'h100, 32'hAABB_CCDD, 4'hF);
    tick();
    ex_wr(4'd1, 32'h101, 32'h0000_EE00, 4'h2);
    tick();
    ex_valid_i = 1'b0;
    load_addr_i = 32'h100; load_be_i = 4'hF;
    settle();
    chk("fwd_hit", 64'(load_hit_o), 64'd1);
    chk("fwd_stall", 64'(load_stall_o), 64'd0);
    chk("fwd_data", 64'(load_data_o), 64'hAABB_EEDD);
    load_addr_i = 32'h103; load_be_i = 4'h2;
    settle();
    chk("fwd_byte1_hit", 64'(load_hit_o), 64'd1);
    chk("fwd_byte1_data", 64'(load_data_o), 64'h0000_EE00);
    load_be_i = 4'h0;
    settle();
    chk("fwd_be0_hit", 64'(load_hit_o), 64'd0);
    chk("fwd_be0_stall", 64'(load_stall_o), 64'd0);

    // Partial overlap stall and miss
    alloc_req_i = 2'b01;
    settle();
    chk("single_id", 64'(alloc_id_o[IDW-1:0]), 64'd2);
    tick();
    alloc_req_i = '0;
    ex_wr(4'd2, 32'h200, 32'h0000_1234, 4'h3);
    tick();
    ex_valid_i = 1'b0;
    load_addr_i = 32'h200; load_be_i = 4'hF;
    settle();
    chk("part_stall", 64'(load_stall_o), 64'd1);
    chk("part_hit", 64'(load_hit_o), 64'd0);
    chk("part_data", 64'(load_data_o), 64'h0000_1234);
    load_addr_i = 32'h204;
    settle();
    chk("miss_hit", 64'(load_hit_o), 64'd0);
    chk("miss_stall", 64'(load_stall_o), 64'd0);
    chk("miss_data", 64'(load_data_o), 64'd0);
    do_reset();

    // Commit 0,1 in the flush cycle; the allocation request that cycle is ignored
    alloc_req_i = 2'b11;
    tick();
    tick();
    alloc_req_i = '0;
    ex_wr(4'd0, 32'h300, 32'h0101_0101, 4'hF);
    tick();
    ex_wr(4'd1, 32'h304, 32'h0202_0202, 4'h3);
    tick();
    ex_wr(4'd2, 32'h308, 32'h0303_0303, 4'hF);
    tick();
    ex_valid_i = 1'b0;
    settle();
    chk("pre_flush_count", 64'(count_o), 64'd4);
    commit_valid_i = 2'b11; commit_sb_id_i = {4'd1, 4'd0};
    flush_i = 1'b1; alloc_req_i = 2'b11;
    push_exp(32'h300, 32'h0101_0101, 4'hF);
    push_exp(32'h304, 32'h0202_0202, 4'h3);
    tick();
    commit_valid_i = '0; flush_i = 1'b0; alloc_req_i = '0;
    load_addr_i = 32'h308; load_be_i = 4'hF;
    settle();
    chk("flush_count", 64'(count_o), 64'd2);
    chk("flush_tail", 64'(alloc_id_o[IDW-1:0]), 64'd2);
    chk("flush_dvalid", 64'(dcache_req_valid_o), 64'd1);
    chk("flush_spec_gone", 64'(load_hit_o), 64'd0);
    load_addr_i = 32'h300;
    settle();
    chk("flush_senior_fwd", 64'(load_hit_o), 64'd1);
    dcache_req_ready_i = 1'b1;
    tick();
    chk("drain1_count", 64'(count_o), 64'd1);
    tick();
    dcache_req_ready_i = 1'b0;
    settle();
    chk("drain2_count", 64'(count_o), 64'd0);
    chk("drain2_dvalid", 64'(dcache_req_valid_o), 64'd0);
    do_reset();

    // Backpressure: request held stable while ready is low
    alloc_req_i = 2'b01;
    tick();
    alloc_req_i = '0;
    ex_wr(4'd0, 32'h400, 32'hCAFE_F00D, 4'hF);
    commit_valid_i = 2'b01; commit_sb_id_i = {4'd0, 4'd0};
    push_exp(32'h400, 32'hCAFE_F00D, 4'hF);
    tick();
    ex_valid_i = 1'b0; commit_valid_i = '0;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("hold_dvalid", 64'(dcache_req_valid_o), 64'd1);
      chk("hold_addr", 64'(dcache_req_addr_o), 64'h400);
      chk("hold_data", 64'(dcache_req_data_o), 64'hCAFE_F00D);
      chk("hold_be", 64'(dcache_req_be_o), 64'hF);
      tick();
    end
    dcache_req_ready_i = 1'b1;
    tick();
    dcache_req_ready_i = 1'b0;
    settle();
    chk("hold_done_dvalid", 64'(dcache_req_valid_o), 64'd0);
    chk("hold_done_count", 64'(count_o), 64'd0);

    tick();
    chk("exp_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
